wb_arbiter: RTL and testbench

- Writer side of the decode-stage register file.
- Merges register-write requests from three producers into the file's single write port (RegWrite/waddr/wb_data):
  - ALU, single-cycle, no backpressure;
  - load unit, valid/ready;
  - mul/div unit, valid/ready.
- Keeps a 32-bit busy scoreboard for long-latency destinations so decode can detect RAW hazards on rs/rt.

---
 rtl/wb_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter with busy scoreboard.
// The ALU always wins. Load and mul/div share the remaining slots by round robin.
// Long-latency destinations are tracked in a busy vector that feeds a RAW hazard flag.
// Optional macro WB_BYPASS_EN enables same-cycle forwarding of the value being written.
module wb_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       alu_valid,
   input  logic [ADDR_W-1:0]          alu_addr,
   input  logic [DATA_W-1:0]          alu_data,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [ADDR_W-1:0]          ld_addr,
   input  logic [DATA_W-1:0]          ld_data,
   input  logic                       md_valid,
   output logic                       md_ready,
   input  logic [ADDR_W-1:0]          md_addr,
   input  logic [DATA_W-1:0]          md_data,
   input  logic                       iss_valid,
   input  logic [ADDR_W-1:0]          iss_addr,
   input  logic [ADDR_W-1:0]          rs,
   input  logic [ADDR_W-1:0]          rt,
   output logic                       hazard,
   output logic [(1<<ADDR_W)-1:0]     busy,
   output logic                       RegWrite,
   output logic [ADDR_W-1:0]          waddr,
   output logic [DATA_W-1:0]          wb_data,
   output logic                       fwd_a_hit,
   output logic                       fwd_b_hit,
   output logic [DATA_W-1:0]          fwd_data
);

   localparam int unsigned NREG = 1 << ADDR_W;

   logic              rr_q, rr_d;
   logic              regwrite_q, regwrite_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NREG-1:0]   busy_q, busy_d;

   // Grant logic: ALU blocks both, otherwise rr picks between competing load and mul/div
   always_comb begin
      ld_ready = !alu_valid && ld_valid && (!rr_q || !md_valid);
      md_ready = !alu_valid && md_valid && (rr_q || !ld_valid);
   end

   // Next-state for output stage, round-robin pointer and scoreboard
   always_comb begin
      rr_d       = rr_q;
      regwrite_d = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      busy_d     = busy_q;

      if (alu_valid) begin
         regwrite_d = (alu_addr != '0);
         waddr_d    = alu_addr;
         wdata_d    = alu_data;
      end else if (ld_ready) begin
         regwrite_d      = (ld_addr != '0);
         waddr_d         = ld_addr;
         wdata_d         = ld_data;
         rr_d            = 1'b1;
         busy_d[ld_addr] = 1'b0;
      end else if (md_ready) begin
         regwrite_d      = (md_addr != '0);
         waddr_d         = md_addr;
         wdata_d         = md_data;
         rr_d            = 1'b0;
         busy_d[md_addr] = 1'b0;
      end

      // Issue is applied after the clear so a same-cycle set wins
      if (iss_valid && (iss_addr != '0)) begin
         busy_d[iss_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_q       <= 1'b0;
         regwrite_q <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         busy_q     <= '0;
      end else begin
         rr_q       <= rr_d;
         regwrite_q <= regwrite_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
      end
   end

   // RAW hazard on either decode source; register 0 is never busy
   always_comb begin
      hazard = ((rs != '0) && busy_q[rs]) || ((rt != '0) && busy_q[rt]);
   end

   assign busy     = busy_q;
   assign RegWrite = regwrite_q;
   assign waddr    = waddr_q;
   assign wb_data  = wdata_q;

`ifdef WB_BYPASS_EN
   // Forward the value the register file is writing this cycle
   always_comb begin
      fwd_a_hit = regwrite_q && (waddr_q == rs) && (rs != '0);
      fwd_b_hit = regwrite_q && (waddr_q == rt) && (rt != '0);
      fwd_data  = wdata_q;
   end
`else
   assign fwd_a_hit = 1'b0;
   assign fwd_b_hit = 1'b0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU path, priority/round robin,
// scoreboard, address-0 handling, async reset mid-operation and bypass.
`timescale 1ns/1ps
module tb_wb_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        alu_valid, ld_valid, md_valid, iss_valid;
   logic [4:0]  alu_addr, ld_addr, md_addr, iss_addr, rs, rt;
   logic [31:0] alu_data, ld_data, md_data;
   logic        ld_ready, md_ready, hazard, RegWrite, fwd_a_hit, fwd_b_hit;
   logic [31:0] busy, wb_data, fwd_data;
   logic [4:0]  waddr;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clock(clock), .reset(reset),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .rs(rs), .rt(rt),
      .hazard(hazard), .busy(busy), .RegWrite(RegWrite), .waddr(waddr),
      .wb_data(wb_data), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
      .fwd_data(fwd_data)
   );

   // Advance one rising edge and settle 1ns past it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      alu_valid = 0; alu_addr = 0; alu_data = 0;
      ld_valid = 0; ld_addr = 0; ld_data = 0;
      md_valid = 0; md_addr = 0; md_data = 0;
      iss_valid = 0; iss_addr = 0; rs = 0; rt = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 0;
      repeat (3) tick();
      total++;
      if (RegWrite !== 1'b0 || waddr !== 5'd0 || wb_data !== 32'd0 || busy !== 32'd0) begin
         bad++;
         $display("FAIL reset_state: RegWrite=%b waddr=%0d wb_data=%h busy=%h expected 0/0/0/0",
                  RegWrite, waddr, wb_data, busy);
      end
      reset = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (RegWrite !== 1'b0 || busy !== 32'd0 || ld_ready !== 1'b0 || md_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_%0d: RegWrite=%b busy=%h ld_ready=%b md_ready=%b expected all 0",
                     i, RegWrite, busy, ld_ready, md_ready);
         end
      end
   endtask

   task automatic test_alu();
      alu_valid = 1; alu_addr = 8; alu_data = 32'h1234;
      tick();
      alu_valid = 0;
      total++;
      if (RegWrite !== 1'b1 || waddr !== 5'd8 || wb_data !== 32'h1234) begin
         bad++;
         $display("FAIL alu_write: RegWrite=%b waddr=%0d wb_data=%h expected 1/8/00001234",
                  RegWrite, waddr, wb_data);
      end
      tick();
      total++;
      if (RegWrite !== 1'b0 || waddr !== 5'd8 || wb_data !== 32'h1234) begin
         bad++;
         $display("FAIL alu_hold: RegWrite=%b waddr=%0d wb_data=%h expected 0/8/00001234",
                  RegWrite, waddr, wb_data);
      end
   endtask

   task automatic test_priority_rr();
      ld_valid = 1; ld_addr = 9;  ld_data = 32'hA;
      md_valid = 1; md_addr = 10; md_data = 32'hB;
      alu_valid = 1; alu_addr = 1; alu_data = 32'h77;
      #1;
      total++;
      if (ld_ready !== 1'b0 || md_ready !== 1'b0) begin
         bad++;
         $display("FAIL alu_block_0: ld_ready=%b md_ready=%b expected 0/0", ld_ready, md_ready);
      end
      tick();
      total++;
      if (ld_ready !== 1'b0 || md_ready !== 1'b0 || RegWrite !== 1'b1 || waddr !== 5'd1) begin
         bad++;
         $display("FAIL alu_block_1: ld_ready=%b md_ready=%b RegWrite=%b waddr=%0d expected 0/0/1/1",
                  ld_ready, md_ready, RegWrite, waddr);
      end
      tick();
      alu_valid = 0;
      #1;
      total++;
      if (ld_ready !== 1'b1 || md_ready !== 1'b0) begin
         bad++;
         $display("FAIL rr_ld_first: ld_ready=%b md_ready=%b expected 1/0", ld_ready, md_ready);
      end
      tick();
      // Load consumed; present a fresh load so round robin must favour mul/div
      ld_addr = 11; ld_data = 32'hC;
      #1;
      total++;
      if (RegWrite !== 1'b1 || waddr !== 5'd9 || wb_data !== 32'hA || ld_ready !== 1'b0 || md_ready !== 1'b1) begin
         bad++;
         $display("FAIL rr_md_second: RegWrite=%b waddr=%0d wb_data=%h ld_ready=%b md_ready=%b expected 1/9/A/0/1",
                  RegWrite, waddr, wb_data, ld_ready, md_ready);
      end
      tick();
      md_valid = 0;
      #1;
      total++;
      if (RegWrite !== 1'b1 || waddr !== 5'd10 || wb_data !== 32'hB || ld_ready !== 1'b1) begin
         bad++;
         $display("FAIL md_out: RegWrite=%b waddr=%0d wb_data=%h ld_ready=%b expected 1/10/B/1",
                  RegWrite, waddr, wb_data, ld_ready);
      end
      tick();
      ld_valid = 0;
      total++;
      if (RegWrite !== 1'b1 || waddr !== 5'd11 || wb_data !== 32'hC) begin
         bad++;
         $display("FAIL ld_out2: RegWrite=%b waddr=%0d wb_data=%h expected 1/11/C",
                  RegWrite, waddr, wb_data);
      end
      tick();
   endtask

   task automatic test_scoreboard();
      iss_valid = 1; iss_addr = 5;
      tick();
      iss_valid = 0; rs = 5; rt = 0;
      #1;
      total++;
      if (busy !== 32'h20 || hazard !== 1'b1) begin
         bad++;
         $display("FAIL sb_set: busy=%h hazard=%b expected 00000020/1", busy, hazard);
      end
      rs = 0; rt = 5;
      #1;
      total++;
      if (hazard !== 1'b1) begin
         bad++;
         $display("FAIL sb_rt_hazard: hazard=%b expected 1", hazard);
      end
      rt = 6;
      #1;
      total++;
      if (hazard !== 1'b0) begin
         bad++;
         $display("FAIL sb_no_hazard: hazard=%b expected 0", hazard);
      end
      rs = 5; rt = 0;
      ld_valid = 1; ld_addr = 5; ld_data = 32'h55AA;
      #1;
      total++;
      if (ld_ready !== 1'b1 || hazard !== 1'b1) begin
         bad++;
         $display("FAIL sb_ld_accept: ld_ready=%b hazard=%b expected 1/1", ld_ready, hazard);
      end
      tick();
      ld_valid = 0;
      total++;
      if (busy !== 32'd0 || hazard !== 1'b0 || RegWrite !== 1'b1 || wb_data !== 32'h55AA) begin
         bad++;
         $display("FAIL sb_clear: busy=%h hazard=%b RegWrite=%b wb_data=%h expected 0/0/1/55AA",
                  busy, hazard, RegWrite, wb_data);
      end
      iss_valid = 1; iss_addr = 5;
      tick();
      iss_valid = 1; iss_addr = 5;
      ld_valid = 1; ld_addr = 5;
      tick();
      iss_valid = 0; ld_valid = 0;
      total++;
      if (busy !== 32'h20) begin
         bad++;
         $display("FAIL sb_set_wins: busy=%h expected 00000020", busy);
      end
      iss_valid = 1; iss_addr = 7;
      md_valid = 1; md_addr = 5; md_data = 32'h9;
      tick();
      iss_valid = 0; md_valid = 0;
      total++;
      if (busy !== 32'h80) begin
         bad++;
         $display("FAIL sb_md_clear: busy=%h expected 00000080", busy);
      end
      ld_valid = 1; ld_addr = 7;
      alu_valid = 1; alu_addr = 7; alu_data = 32'h3;
      tick();
      alu_valid = 0;
      total++;
      if (busy !== 32'h80) begin
         bad++;
         $display("FAIL sb_alu_no_touch: busy=%h expected 00000080", busy);
      end
      tick();
      ld_valid = 0; rs = 0;
      total++;
      if (busy !== 32'd0) begin
         bad++;
         $display("FAIL sb_final_clear: busy=%h expected 0", busy);
      end
   endtask

   task automatic test_addr_zero();
      ld_valid = 1; ld_addr = 0; ld_data = 32'hFFFF;
      iss_valid = 1; iss_addr = 0;
      #1;
      total++;
      if (ld_ready !== 1'b1) begin
         bad++;
         $display("FAIL zero_ready: ld_ready=%b expected 1", ld_ready);
      end
      tick();
      ld_valid = 0; iss_valid = 0;
      total++;
      if (RegWrite !== 1'b0 || busy !== 32'd0 || hazard !== 1'b0) begin
         bad++;
         $display("FAIL zero_write: RegWrite=%b busy=%h hazard=%b expected 0/0/0",
                  RegWrite, busy, hazard);
      end
   endtask

   task automatic test_async_reset();
      iss_valid = 1; iss_addr = 6;
      tick();
      iss_valid = 0;
      alu_valid = 1; alu_addr = 2; alu_data = 32'hBEEF;
      tick();
      alu_valid = 0;
      total++;
      if (busy !== 32'h40 || RegWrite !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset: busy=%h RegWrite=%b expected 00000040/1", busy, RegWrite);
      end
      #2 reset = 0;
      #1;
      total++;
      if (busy !== 32'd0 || RegWrite !== 1'b0 || waddr !== 5'd0 || wb_data !== 32'd0) begin
         bad++;
         $display("FAIL async_reset: busy=%h RegWrite=%b waddr=%0d wb_data=%h expected all 0",
                  busy, RegWrite, waddr, wb_data);
      end
      tick();
      reset = 1;
      tick();
   endtask

   task automatic test_bypass();
      alu_valid = 1; alu_addr = 3; alu_data = 32'h55;
      rs = 3; rt = 3;
      tick();
      alu_valid = 0;
      #1;
      total++;
`ifdef WB_BYPASS_EN
      if (fwd_a_hit !== 1'b1 || fwd_b_hit !== 1'b1 || fwd_data !== 32'h55) begin
         bad++;
         $display("FAIL bypass_hit: a=%b b=%b data=%h expected 1/1/00000055",
                  fwd_a_hit, fwd_b_hit, fwd_data);
      end
`else
      if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0 || fwd_data !== 32'd0) begin
         bad++;
         $display("FAIL bypass_off: a=%b b=%b data=%h expected 0/0/0",
                  fwd_a_hit, fwd_b_hit, fwd_data);
      end
`endif
      rs = 4;
      #1;
      total++;
`ifdef WB_BYPASS_EN
      if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b1) begin
         bad++;
         $display("FAIL bypass_partial: a=%b b=%b expected 0/1", fwd_a_hit, fwd_b_hit);
      end
`else
      if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0) begin
         bad++;
         $display("FAIL bypass_partial_off: a=%b b=%b expected 0/0", fwd_a_hit, fwd_b_hit);
      end
`endif
      tick();
      total++;
      if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0) begin
         bad++;
         $display("FAIL bypass_after: a=%b b=%b expected 0/0", fwd_a_hit, fwd_b_hit);
      end
      rs = 0; rt = 0;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_priority_rr();
      test_scoreboard();
      test_addr_zero();
      test_async_reset();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
